pc_predictor: RTL and testbench
===============================

PC_PREDICTOR -- requirements
Module: pc_predictor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/address width in bits (>= 8).
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, branch-target-buffer depth (power of 2, >= 2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold PC when high.
REQ-007 SHALL have port redirect_valid  input  1  execute-stage correction request.
REQ-008 SHALL have port redirect_pc  input  WIDTH  corrected next PC.
REQ-009 SHALL have port upd_valid  input  1  resolved control-transfer update strobe.
REQ-010 SHALL have port upd_pc  input  WIDTH  PC of the resolved branch/jump.
REQ-011 SHALL have port upd_taken  input  1  resolved direction.
REQ-012 SHALL have port upd_target  input  WIDTH  resolved target.
REQ-013 SHALL have port pc  output  WIDTH  current fetch PC (registered).
REQ-014 SHALL have port npc  output  WIDTH  next PC (combinational).
REQ-015 SHALL have port pred_taken  output  1  high when npc comes from a BTB prediction.

Function
REQ-016 SHALL define IDX = log2(BTB_ENTRIES); index = PC[IDX+1:2]; tag = PC[WIDTH-1:IDX+2].
REQ-017 SHALL hold per BTB entry: valid bit, tag, target (WIDTH), 2-bit saturating counter.
REQ-018 SHALL compute hit = entry[index(pc)].valid AND tag match; predict = hit AND counter[1].
REQ-019 SHALL select npc with priority: redirect_valid -> redirect_pc; else predict -> entry target; else pc + 4.
REQ-020 SHALL compute pc + 4 modulo 2^WIDTH (wrap from max to 0x...0, no carry out).
REQ-021 SHALL force npc[1:0] = 2'b00 for every source (word alignment).
REQ-022 SHALL drive pred_taken = predict AND NOT redirect_valid.
REQ-023 SHALL load pc <= npc on each rising edge when stall = 0 or redirect_valid = 1 (redirect overrides stall).
REQ-024 SHALL hold pc when stall = 1 and redirect_valid = 0; latency from redirect assertion to pc change is one cycle.
REQ-025 SHALL on upd_valid with hit at index(upd_pc): counter +1 saturating at 2'b11 if upd_taken, else -1 saturating at 2'b00; target <= upd_target when upd_taken.
REQ-026 SHALL on upd_valid with miss and upd_taken = 1: allocate (overwrite) entry: valid=1, tag, target=upd_target, counter=2'b10.
REQ-027 SHALL on upd_valid with miss and upd_taken = 0: leave BTB unchanged.
REQ-028 SHALL make BTB writes visible only from the next cycle; same-cycle lookup at the written index sees old contents.
REQ-029 SHALL perform BTB updates regardless of stall and redirect_valid.
REQ-030 SHALL ignore upd_pc/upd_target values when upd_valid = 0.

Reset
REQ-031 SHALL on rst = 1, immediately and independent of clk, set pc = RESET_PC (bits [1:0] cleared) and all BTB valid bits = 0; counters = 2'b01, targets/tags = 0.
REQ-032 SHALL, with rst asserted, drive npc = RESET_PC + 4 and pred_taken = 0 unless redirect_valid is high.
REQ-033 SHALL, on reset asserted mid-operation, discard any in-flight update and resume from RESET_PC on first edge after rst falls.

Verification
REQ-034 SHALL cover sequential fetch: reset, no stall/update -> pc = 0x0, 0x4, 0x8, 0xC on successive edges; pred_taken = 0.
REQ-035 SHALL cover allocation: upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100; later pc=0x40 -> npc=0x100, pred_taken=1; following edge pc=0x100.
REQ-036 SHALL cover counter hysteresis: after REQ-035, two not-taken updates for 0x40 -> counter 2'b00, pc=0x40 gives npc=0x44; one taken update -> 2'b01, still 0x44; second taken -> 2'b10, npc=0x100.
REQ-037 SHALL cover stall vs redirect: stall=1 holds pc=0x20 three cycles; stall=1 with redirect_valid=1, redirect_pc=0x203 -> pc=0x200 next edge.
REQ-038 SHALL cover wrap and aliasing (WIDTH=32, BTB_ENTRIES=16): pc=0xFFFF_FFFC -> npc=0x0; entry for 0x40 allocated, lookup at 0x440 (same index, different tag) -> miss, npc=0x444.
REQ-039 SHALL cover async reset: rst pulsed between edges while pc=0x100 and BTB populated -> pc=RESET_PC immediately, previously predicted PC then yields pc+4.

Source files
------------

// File: rtl/pc_predictor.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Priority for the next PC: execute redirect, then BTB prediction, then pc + 4.
module pc_predictor #(
    parameter int               WIDTH       = 32,
    parameter int               BTB_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic             pred_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;

    logic [BTB_ENTRIES-1:0] vld;
    logic [TW-1:0]          tags [BTB_ENTRIES];
    logic [WIDTH-1:0]       tgts [BTB_ENTRIES];
    logic [1:0]             ctrs [BTB_ENTRIES];

    logic [IDX-1:0]   fidx;
    logic [IDX-1:0]   uidx;
    logic [TW-1:0]    ftag;
    logic [TW-1:0]    utag;
    logic             hit;
    logic             predict;
    logic             uhit;
    logic [WIDTH-1:0] nxt;

    assign fidx = pc[IDX+1:2];
    assign ftag = pc[WIDTH-1:IDX+2];
    assign uidx = upd_pc[IDX+1:2];
    assign utag = upd_pc[WIDTH-1:IDX+2];

    assign hit     = vld[fidx] && (tags[fidx] == ftag);
    assign predict = hit && ctrs[fidx][1];
    assign uhit    = vld[uidx] && (tags[uidx] == utag);

    always_comb begin
        nxt = pc + WIDTH'(4);
        if (redirect_valid) begin
            nxt = redirect_pc;
        end else if (predict) begin
            nxt = tgts[fidx];
        end
    end

    assign npc        = {nxt[WIDTH-1:2], 2'b00};
    assign pred_taken = predict && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= {RESET_PC[WIDTH-1:2], 2'b00};
        end else if (!stall || redirect_valid) begin
            pc <= npc;
        end
    end

    // BTB training runs independently of stall/redirect so no resolution is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tags[i] <= '0;
                tgts[i] <= '0;
                ctrs[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (uhit) begin
                if (upd_taken) begin
                    tgts[uidx] <= upd_target;
                    if (ctrs[uidx] != 2'b11) begin
                        ctrs[uidx] <= ctrs[uidx] + 2'd1;
                    end
                end else if (ctrs[uidx] != 2'b00) begin
                    ctrs[uidx] <= ctrs[uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                vld[uidx]  <= 1'b1;
                tags[uidx] <= utag;
                tgts[uidx] <= upd_target;
                ctrs[uidx] <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: sequential fetch, BTB training,
// stall/redirect interplay, wrap/aliasing and asynchronous reset.
module tb_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        pred_taken;

    int checks = 0;
    int errors = 0;

    pc_predictor #(
        .WIDTH(32),
        .BTB_ENTRIES(16),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .pc(pc),
        .npc(npc),
        .pred_taken(pred_taken)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic upd(input logic [31:0] p, input logic t,
                       input logic [31:0] tg);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_taken  = t;
        upd_target = tg;
        tick();
        upd_valid  = 1'b0;
        upd_pc     = 32'hDEAD_BEEF;
        upd_target = 32'hBAD0_BAD0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        #2;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        checks++;
        if (npc !== 32'h4) begin
            errors++;
            $display("FAIL reset_npc: got %h want %h", npc, 32'h4);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_pred: got %b want 0", pred_taken);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", pc, 32'h0);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        exp = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc !== exp || pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: got pc %h pred %b want %h pred 0",
                         i, pc, pred_taken, exp);
            end
            exp = exp + 32'h4;
            tick();
        end
    endtask

    task automatic test_alloc();
        goto(32'h40);
        stall = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h100;
        #1;
        checks++;
        if (npc !== 32'h44 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL alloc_same_cycle: got %h/%b want 00000044/0",
                     npc, pred_taken);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h40 || npc !== 32'h100 || pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL alloc_predict: got pc %h npc %h pred %b want 40/100/1",
                     pc, npc, pred_taken);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL alloc_follow: got %h want %h", pc, 32'h100);
        end
    endtask

    task automatic test_hysteresis();
        goto(32'h40);
        stall = 1'b1;
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        checks++;
        if (npc !== 32'h44 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL hyst_00: got %h/%b want 00000044/0", npc, pred_taken);
        end
        upd(32'h40, 1'b0, 32'h0);
        checks++;
        if (npc !== 32'h44) begin
            errors++;
            $display("FAIL hyst_sat_low: got %h want %h", npc, 32'h44);
        end
        upd(32'h40, 1'b1, 32'h100);
        checks++;
        if (npc !== 32'h44 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL hyst_01: got %h/%b want 00000044/0", npc, pred_taken);
        end
        upd(32'h40, 1'b1, 32'h100);
        checks++;
        if (npc !== 32'h100 || pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL hyst_10: got %h/%b want 00000100/1", npc, pred_taken);
        end
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        checks++;
        if (npc !== 32'h100 || pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL hyst_sat_high: got %h/%b want 00000100/1",
                     npc, pred_taken);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        checks++;
        if (npc !== 32'h300 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL redirect_prio: got %h/%b want 00000300/0",
                     npc, pred_taken);
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
    endtask

    task automatic test_stall_redirect();
        goto(32'h20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h20) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, pc, 32'h20);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        checks++;
        if (npc !== 32'h200) begin
            errors++;
            $display("FAIL redirect_align: got %h want %h", npc, 32'h200);
        end
        tick();
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL stall_redirect: got %h want %h", pc, 32'h200);
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
    endtask

    task automatic test_wrap_alias();
        goto(32'hFFFF_FFFC);
        checks++;
        if (npc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_npc: got %h want %h", npc, 32'h0);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %h want %h", pc, 32'h0);
        end
        goto(32'h440);
        checks++;
        if (npc !== 32'h444 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL alias: got %h/%b want 00000444/0", npc, pred_taken);
        end
    endtask

    task automatic test_async_reset();
        goto(32'h40);
        tick();
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL areset_setup: got %h want %h", pc, 32'h100);
        end
        #2;
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        #1;
        checks++;
        if (pc !== 32'h0 || npc !== 32'h4 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got pc %h npc %h pred %b want 0/4/0",
                     pc, npc, pred_taken);
        end
        tick();
        rst       = 1'b0;
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL areset_resume: got %h want %h", pc, 32'h0);
        end
        tick();
        checks++;
        if (pc !== 32'h4) begin
            errors++;
            $display("FAIL areset_first_edge: got %h want %h", pc, 32'h4);
        end
        goto(32'h100);
        checks++;
        if (npc !== 32'h104 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL areset_discard: got %h/%b want 00000104/0",
                     npc, pred_taken);
        end
        goto(32'h40);
        checks++;
        if (npc !== 32'h44 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL areset_btb_clear: got %h/%b want 00000044/0",
                     npc, pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_alloc();
        test_hysteresis();
        test_stall_redirect();
        test_wrap_alias();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
